// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the two-requester FP multiplier arbiter.
package fp_arb_pkg;

    localparam int FP_W      = 32;
    localparam int GAP_CNT_W = 8;

    typedef logic req_id_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        GAP,
        SEND_B,
        WAIT_RES,
        ACK_RES,
        RESPOND
    } arb_state_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-input round-robin grant. Holds the last-grant pointer and advances it on
// every issued grant; the pointer resets to 1 so requester 0 wins first.
module rr_grant2
    import fp_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic       gnt_vld_o,
    output req_id_t    gnt_id_o
);

    req_id_t last_q;
    req_id_t last_d;

    // Prefer the requester that did not win last time; otherwise take whoever asks.
    always_comb begin
        gnt_vld_o = en_i && (req_i != 2'b00);
        if (last_q == 1'b1) begin
            gnt_id_o = req_i[0] ? 1'b0 : 1'b1;
        end else begin
            gnt_id_o = req_i[1] ? 1'b1 : 1'b0;
        end
        last_d = gnt_vld_o ? gnt_id_o : last_q;
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one FP multiplier between two requesters. Operands go out as two
// words (A, gap, B) on a ready/accept bus; the product is captured, acked and
// returned to the granted requester only.
//
// state    | meaning
// IDLE     | no transaction; arbitrate pending requests
// SEND_A   | present operand A until the multiplier accepts it
// GAP      | mulInReady low for GAP_CYCLES cycles
// SEND_B   | present operand B until the multiplier accepts it
// WAIT_RES | wait for mulResultReady, capture the product
// ACK_RES  | hold mulResultAccept until mulResultReady drops
// RESPOND  | rspNValid to the granted requester until it accepts
module fp_mul_arbiter
    import fp_arb_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0Valid,
    input  logic            req1Valid,
    input  logic [FP_W-1:0] req0A,
    input  logic [FP_W-1:0] req0B,
    input  logic [FP_W-1:0] req1A,
    input  logic [FP_W-1:0] req1B,
    output logic            req0Ready,
    output logic            req1Ready,
    output logic            rsp0Valid,
    output logic            rsp1Valid,
    output logic [FP_W-1:0] rspData,
    input  logic            rsp0Accept,
    input  logic            rsp1Accept,
    output logic [FP_W-1:0] mulInBus,
    output logic            mulInReady,
    input  logic            mulInAccept,
    input  logic [FP_W-1:0] mulOutBus,
    input  logic            mulResultReady,
    output logic            mulResultAccept,
    output logic            busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

    arb_state_t           state_q, state_d;
    logic [FP_W-1:0]      a_q, a_d;
    logic [FP_W-1:0]      b_q, b_d;
    logic [FP_W-1:0]      rsp_q, rsp_d;
    req_id_t              id_q, id_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;

    logic    gnt_vld;
    req_id_t gnt_id;

    // Grant only from IDLE and never while reset is held, so no ready pulse leaks out.
    rr_grant2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .en_i      ((state_q == IDLE) && rst),
        .req_i     ({req1Valid, req0Valid}),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    // Next-state, datapath next values and Moore/grant outputs.
    always_comb begin
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        rsp_d           = rsp_q;
        id_d            = id_q;
        gap_d           = gap_q;
        req0Ready       = 1'b0;
        req1Ready       = 1'b0;
        rsp0Valid       = 1'b0;
        rsp1Valid       = 1'b0;
        mulInBus        = '0;
        mulInReady      = 1'b0;
        mulResultAccept = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    a_d       = (gnt_id == 1'b1) ? req1A : req0A;
                    b_d       = (gnt_id == 1'b1) ? req1B : req0B;
                    id_d      = gnt_id;
                    req0Ready = (gnt_id == 1'b0);
                    req1Ready = (gnt_id == 1'b1);
                    state_d   = SEND_A;
                end
            end
            SEND_A: begin
                mulInReady = 1'b1;
                mulInBus   = a_q;
                if (mulInAccept) begin
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = SEND_B;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            SEND_B: begin
                mulInReady = 1'b1;
                mulInBus   = b_q;
                if (mulInAccept) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (mulResultReady) begin
                    rsp_d   = mulOutBus;
                    state_d = ACK_RES;
                end
            end
            ACK_RES: begin
                mulResultAccept = 1'b1;
                if (!mulResultReady) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                rsp0Valid = (id_q == 1'b0);
                rsp1Valid = (id_q == 1'b1);
                if (((id_q == 1'b0) && rsp0Accept) || ((id_q == 1'b1) && rsp1Accept)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign rspData = rsp_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rsp_q   <= '0;
            id_q    <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rsp_q   <= rsp_d;
            id_q    <= id_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter; the bench itself plays the multiplier.
module tb_fp_mul_arbiter;

    localparam int GAP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0Valid, req1Valid;
    logic [31:0] req0A, req0B, req1A, req1B;
    logic        req0Ready, req1Ready;
    logic        rsp0Valid, rsp1Valid;
    logic [31:0] rspData;
    logic        rsp0Accept, rsp1Accept;
    logic [31:0] mulInBus;
    logic        mulInReady;
    logic        mulInAccept;
    logic [31:0] mulOutBus;
    logic        mulResultReady;
    logic        mulResultAccept;
    logic        busy;

    fp_mul_arbiter #(.GAP_CYCLES(GAP)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .req0Valid       (req0Valid),
        .req1Valid       (req1Valid),
        .req0A           (req0A),
        .req0B           (req0B),
        .req1A           (req1A),
        .req1B           (req1B),
        .req0Ready       (req0Ready),
        .req1Ready       (req1Ready),
        .rsp0Valid       (rsp0Valid),
        .rsp1Valid       (rsp1Valid),
        .rspData         (rspData),
        .rsp0Accept      (rsp0Accept),
        .rsp1Accept      (rsp1Accept),
        .mulInBus        (mulInBus),
        .mulInReady      (mulInReady),
        .mulInAccept     (mulInAccept),
        .mulOutBus       (mulOutBus),
        .mulResultReady  (mulResultReady),
        .mulResultAccept (mulResultAccept),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] prod;
        int          dly;
        int          hold;
        int          exp_id;
    } vec_t;

    vec_t vecs[8];
    vec_t r0, p0;

    int nchk = 0;
    int npass = 0;
    int stable_err = 0;
    int rdy_extra = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        else npass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_ready();
        if (req0Ready || req1Ready) rdy_extra++;
    endtask

    function automatic logic any_out();
        return |{req0Ready, req1Ready, rsp0Valid, rsp1Valid, rspData,
                 mulInBus, mulInReady, mulResultAccept, busy};
    endfunction

    // One operand word: wait for mulInReady, accept it on ready cycle dly+1.
    task automatic send_word(input int dly, output logic [31:0] w, output int n, output int waited);
        int guard;
        guard  = 0;
        n      = 0;
        waited = 0;
        mulInAccept = (dly == 0);
        #1;
        while (!mulInReady && guard < 40) begin
            tick(); waited++; guard++; note_ready();
        end
        w = mulInBus;
        while (mulInReady && guard < 80) begin
            if (mulInBus !== w) stable_err++;
            n++;
            if (n > dly) mulInAccept = 1'b1;
            tick(); guard++; note_ready();
        end
        if (dly != 0) mulInAccept = 1'b0;
    endtask

    // Grant plus both operand words; returns at the first WAIT_RES sample.
    task automatic start_txn(input vec_t v, input int idx, output int gid);
        logic [31:0] wa, wb;
        int na, nb, wta, wtb, g;
        stable_err = 0;
        rdy_extra  = 0;
        req0Valid = v.v0; req1Valid = v.v1;
        req0A = v.a0; req0B = v.b0; req1A = v.a1; req1B = v.b1;
        #1;
        g = 0;
        while (!(req0Ready || req1Ready) && g < 20) begin tick(); g++; end
        chk($sformatf("v%0d grant_seen", idx), 64'(g < 20), 64'd1);
        gid = req1Ready ? 1 : 0;
        chk($sformatf("v%0d grant_id", idx), 64'(gid), 64'(v.exp_id));
        tick();
        if (gid == 0) begin
            req0Valid = 1'b0; req0A = 32'hBAD0_0A0A; req0B = 32'hBAD0_0B0B;
        end else begin
            req1Valid = 1'b0; req1A = 32'hBAD1_1A1A; req1B = 32'hBAD1_1B1B;
        end
        send_word(v.dly, wa, na, wta);
        send_word(v.dly, wb, nb, wtb);
        chk($sformatf("v%0d word_A", idx), 64'(wa), 64'(v.exp_id == 1 ? v.a1 : v.a0));
        chk($sformatf("v%0d word_B", idx), 64'(wb), 64'(v.exp_id == 1 ? v.b1 : v.b0));
        chk($sformatf("v%0d ready_cycles_A", idx), 64'(na), 64'(v.dly + 1));
        chk($sformatf("v%0d ready_cycles_B", idx), 64'(nb), 64'(v.dly + 1));
        chk($sformatf("v%0d gap_cycles", idx), 64'(wtb), 64'(GAP));
        chk($sformatf("v%0d bus_stable_errs", idx), 64'(stable_err), 64'd0);
        chk($sformatf("v%0d ready_midtxn", idx), 64'(rdy_extra), 64'd0);
    endtask

    // Result handshake and response; returns at the first IDLE sample.
    task automatic finish_txn(input vec_t v, input int idx);
        int acc_len, guard;
        mulResultReady = 1'b0;
        #1;
        chk($sformatf("v%0d wait_busy_noack", idx), 64'({busy, mulResultAccept}), 64'b10);
        tick();
        mulOutBus = v.prod;
        mulResultReady = 1'b1;
        #1;
        chk($sformatf("v%0d ack_before_capture", idx), 64'(mulResultAccept), 64'd0);
        tick();
        acc_len = 0;
        guard = 0;
        while (mulResultAccept && guard < 40) begin
            acc_len++;
            if (acc_len >= v.hold) mulResultReady = 1'b0;
            tick(); guard++;
        end
        chk($sformatf("v%0d ack_cycles", idx), 64'(acc_len), 64'(v.hold));
        mulOutBus = 32'hDEAD_BEEF;
        chk($sformatf("v%0d rsp_valids", idx), 64'({rsp1Valid, rsp0Valid}),
            64'(v.exp_id == 1 ? 2'b10 : 2'b01));
        chk($sformatf("v%0d rsp_data", idx), 64'(rspData), 64'(v.prod));
        mulResultReady = 1'b1;
        if (v.exp_id == 0) rsp1Accept = 1'b1; else rsp0Accept = 1'b1;
        tick(); tick();
        chk($sformatf("v%0d wrong_accept_ignored", idx),
            64'({busy, (v.exp_id == 1) ? rsp1Valid : rsp0Valid, rspData}),
            {30'd0, 2'b11, v.prod});
        mulResultReady = 1'b0;
        rsp0Accept = 1'b0; rsp1Accept = 1'b0;
        if (v.exp_id == 0) rsp0Accept = 1'b1; else rsp1Accept = 1'b1;
        tick();
        rsp0Accept = 1'b0; rsp1Accept = 1'b0;
        chk($sformatf("v%0d back_idle", idx), 64'({busy, rsp1Valid, rsp0Valid}), 64'd0);
        chk($sformatf("v%0d rsp_data_held", idx), 64'(rspData), 64'(v.prod));
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int gid;
        start_txn(v, idx, gid);
        finish_txn(v, idx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid, bad;

        //          v0    v1    a0            b0            a1            b1            prod          dly hold id
        vecs[0] = '{1'b1, 1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40000000, 0, 1, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h40A00000, 32'h40C00000, 32'h40400000, 32'h40800000, 32'h41400000, 0, 2, 1};
        vecs[2] = '{1'b1, 1'b1, 32'hBF800000, 32'h41200000, 32'h40400000, 32'h40800000, 32'hC1200000, 1, 1, 0};
        vecs[3] = '{1'b0, 1'b1, 32'h11111111, 32'h22222222, 32'h3F000000, 32'h3F000000, 32'h3E800000, 0, 3, 1};
        vecs[4] = '{1'b0, 1'b1, 32'h11111111, 32'h22222222, 32'h7F800000, 32'h3F800000, 32'h7F800000, 2, 1, 1};
        vecs[5] = '{1'b1, 1'b0, 32'h42FA4000, 32'h41410000, 32'h33333333, 32'h44444444, 32'h44BCAA40, 5, 4, 0};
        vecs[6] = '{1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40800000, 0, 1, 1};
        vecs[7] = '{1'b1, 1'b0, 32'h00000000, 32'hC0000000, 32'h55555555, 32'h66666666, 32'h80000000, 0, 1, 0};
        r0      = '{1'b1, 1'b0, 32'h40400000, 32'h40400000, 32'h77777777, 32'h88888888, 32'h41100000, 0, 1, 0};
        p0      = '{1'b1, 1'b1, 32'h41000000, 32'h3E000000, 32'h40400000, 32'h40400000, 32'h3F800000, 0, 2, 0};

        rst = 1'b0;
        req0Valid = 1'b0; req1Valid = 1'b0;
        req0A = '0; req0B = '0; req1A = '0; req1B = '0;
        rsp0Accept = 1'b0; rsp1Accept = 1'b0;
        mulInAccept = 1'b0; mulOutBus = '0; mulResultReady = 1'b0;
        tick(); tick(); tick();
        chk("reset_outputs", 64'(any_out()), 64'd0);
        rst = 1'b1;
        tick();

        // Stale product while idle must be ignored.
        mulResultReady = 1'b1;
        mulOutBus = 32'hCAFE_F00D;
        tick(); tick();
        chk("stale_idle_ignored", {29'd0, busy, mulResultAccept, rsp0Valid, rspData}, 64'd0);
        mulResultReady = 1'b0;
        mulOutBus = '0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Reset while waiting for the product abandons the transaction.
        start_txn(r0, 8, gid);
        mulInAccept = 1'b0;
        req0Valid = 1'b1;
        rst = 1'b0;
        tick();
        chk("rst_wait_res_outputs", 64'(any_out()), 64'd0);
        tick();
        chk("rst_no_response", 64'({rsp1Valid, rsp0Valid, busy}), 64'd0);
        rst = 1'b1;
        run_txn(p0, 9);

        req0Valid = 1'b0; req1Valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp0Valid || rsp1Valid || busy) bad++;
        end
        chk("single_response_quiet", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
